// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding and
// default timing/geometry parameters.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_SRAM_AW     = 18;

  // One spare bit so the terminal value never sits at the top of the range.
  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles) + 1;
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_wait_counter.sv
// Wait-state counter for one SRAM half access: cleared when idle, counts while
// enabled and flags the last cycle of the half phase.
module wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW     = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit MEM-stage load/store into low/high 16-bit accesses on a
// wait-stated single-port SRAM, freezing the pipeline until the access ends.
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        st_val,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_wr;
  logic [SRAM_AW-2:0] r_haddr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               w_req;
  logic               w_start;
  logic               w_cnt_en;
  logic               w_cnt_clr;
  logic               w_tc;
  logic               w_unused_addr;

  assign w_req         = mem_r_en | mem_w_en;
  assign w_start       = (r_state == ST_IDLE) && w_req;
  assign w_cnt_en      = (r_state == ST_LO) || (r_state == ST_HI);
  assign w_cnt_clr     = ~w_cnt_en | w_tc;
  assign w_unused_addr = ^{address[31:SRAM_AW+1], address[1:0]};

  wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = ST_LO;
      ST_LO:   if (w_tc)  w_state_nxt = ST_HI;
      ST_HI:   if (w_tc)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    case (r_state)
      ST_LO: begin
        sram_addr = {r_haddr, 1'b0};
        if (r_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = r_wdata[15:0];
        end
      end
      ST_HI: begin
        sram_addr = {r_haddr, 1'b1};
        if (r_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = r_wdata[31:16];
        end
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Request is latched at launch so a dropped request still finishes as issued;
  // a simultaneous read+write request is a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= 1'b0;
    end else if (w_start) begin
      r_wr <= mem_w_en;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_haddr <= address[SRAM_AW:2];
      r_wdata <= st_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (!r_wr && w_tc) begin
      if (r_state == ST_LO) begin
        r_rdata[15:0] <= sram_dq_in;
      end else begin
        r_rdata[31:16] <= sram_dq_in;
      end
    end
  end

  assign rdata  = r_rdata;
  assign freeze = w_req & ~ready;

endmodule
